// File: rtl/tone_gen.sv
// Square-wave tone generator: seven-note table scaled from CLK_HZ, four octaves,
// note changes applied only at period ends, and a PWM carrier gating the volume.
module tone_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 20,
    parameter int VOL_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    input  logic [VOL_W-1:0] volume,
    output logic             speaker,
    output logic             active,
    output logic             period_end
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    localparam int HALF_1 = CLK_HZ / (2 * 262);
    localparam int HALF_2 = CLK_HZ / (2 * 294);
    localparam int HALF_3 = CLK_HZ / (2 * 330);
    localparam int HALF_4 = CLK_HZ / (2 * 349);
    localparam int HALF_5 = CLK_HZ / (2 * 392);
    localparam int HALF_6 = CLK_HZ / (2 * 440);
    localparam int HALF_7 = CLK_HZ / (2 * 494);

    // The lowest note in the lowest octave is the longest half-period the counter must reach.
    generate
        if ((longint'(HALF_1) << 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_too_small
            $error("tone_gen: CNT_W too small for octave-0 half-period of note 1");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] half_eff(input logic [2:0] n, input logic [1:0] oct);
        logic [CNT_W-1:0] base;
        case (n)
            3'd1:    base = CNT_W'(HALF_1);
            3'd2:    base = CNT_W'(HALF_2);
            3'd3:    base = CNT_W'(HALF_3);
            3'd4:    base = CNT_W'(HALF_4);
            3'd5:    base = CNT_W'(HALF_5);
            3'd6:    base = CNT_W'(HALF_6);
            3'd7:    base = CNT_W'(HALF_7);
            default: base = '0;
        endcase
        case (oct)
            2'd0:    half_eff = base << 1;
            2'd1:    half_eff = base;
            2'd2:    half_eff = base >> 1;
            default: half_eff = base >> 2;
        endcase
    endfunction

    logic [0:0]       state_q, state_d;
    logic [2:0]       cur_note_q, cur_note_d;
    logic [1:0]       oct_q, oct_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [VOL_W-1:0] vcnt_q, vcnt_d;
    logic             period_end_q, period_end_d;
    logic             note_ok;
    logic             half_done;

    assign note_ok   = ~note[3] & (note[2:0] != 3'd0);
    assign half_done = (cnt_q == half_eff(cur_note_q, oct_q) - CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        cur_note_d   = cur_note_q;
        oct_d        = oct_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        period_end_d = 1'b0;
        vcnt_d       = vcnt_q + VOL_W'(1);

        if (!enable) begin
            state_d    = S_IDLE;
            cur_note_d = 3'd0;
            cnt_d      = '0;
            phase_d    = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (note_ok) begin
                state_d    = S_PLAY;
                cur_note_d = note[2:0];
                oct_d      = octave;
                cnt_d      = '0;
                phase_d    = 1'b1;
            end
        end else if (half_done) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            // Only the falling edge of phase is a period boundary where inputs are taken.
            if (phase_q) begin
                period_end_d = 1'b1;
                if (note_ok) begin
                    cur_note_d = note[2:0];
                    oct_d      = octave;
                end else begin
                    state_d    = S_IDLE;
                    cur_note_d = 3'd0;
                end
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_note_q   <= 3'd0;
            oct_q        <= 2'd1;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            vcnt_q       <= '0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_note_q   <= cur_note_d;
            oct_q        <= oct_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            vcnt_q       <= vcnt_d;
            period_end_q <= period_end_d;
        end
    end

    assign speaker    = phase_q & (vcnt_q < volume);
    assign active     = (state_q == S_PLAY);
    assign period_end = period_end_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: directed scenarios plus random note/octave/volume/enable traffic,
// every cycle compared against a half-period countdown model of the tone.
module tb_tone_gen;

    localparam int CLK_HZ = 100_000;
    localparam int VOL_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [3:0]       note;
    logic [1:0]       octave;
    logic [VOL_W-1:0] volume;
    logic             speaker;
    logic             active;
    logic             period_end;

    always #5 clk = ~clk;

    tone_gen #(
        .CLK_HZ(CLK_HZ),
        .CNT_W (20),
        .VOL_W (VOL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .note      (note),
        .octave    (octave),
        .volume    (volume),
        .speaker   (speaker),
        .active    (active),
        .period_end(period_end)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: whether a tone is sounding, its note/octave, level,
    // cycles left in the current half, and cycles since reset (carrier position).
    bit m_play;
    int m_note;
    int m_oct;
    bit m_phase;
    int m_left;
    int m_cyc;
    bit m_pe;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_half(input int n, input int oct);
        int freq[7] = '{262, 294, 330, 349, 392, 440, 494};
        int base;
        base = CLK_HZ / (2 * freq[n-1]);
        case (oct)
            0:       return base * 2;
            1:       return base;
            2:       return base / 2;
            default: return base / 4;
        endcase
    endfunction

    function automatic bit is_tone(input int n);
        return (n >= 1) && (n <= 7);
    endfunction

    task automatic model_edge();
        int n;
        n = int'(note);
        m_pe = 1'b0;
        if (rst) begin
            m_play  = 1'b0;
            m_note  = 0;
            m_oct   = 1;
            m_phase = 1'b0;
            m_left  = 0;
            m_cyc   = 0;
        end else begin
            m_cyc++;
            if (!enable) begin
                m_play  = 1'b0;
                m_note  = 0;
                m_phase = 1'b0;
                m_left  = 0;
            end else if (!m_play) begin
                if (is_tone(n)) begin
                    m_play  = 1'b1;
                    m_note  = n;
                    m_oct   = int'(octave);
                    m_phase = 1'b1;
                    m_left  = ref_half(m_note, m_oct);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_phase) begin
                        m_pe    = 1'b1;
                        m_phase = 1'b0;
                        if (is_tone(n)) begin
                            m_note = n;
                            m_oct  = int'(octave);
                            m_left = ref_half(m_note, m_oct);
                        end else begin
                            m_play = 1'b0;
                            m_note = 0;
                        end
                    end else begin
                        m_phase = 1'b1;
                        m_left  = ref_half(m_note, m_oct);
                    end
                end
            end
        end
    endtask

    task automatic step();
        bit exp_spk;
        @(posedge clk);
        model_edge();
        #1;
        exp_spk = m_phase && ((m_cyc % 8) < int'(volume));
        chk_eq("speaker", speaker, exp_spk);
        chk_eq("active", active, m_play);
        chk_eq("period_end", period_end, m_pe);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        note   = 4'd0;
        octave = 2'd1;
        volume = 3'd7;
        run(3);
        rst = 1'b0;
        run(2);

        // Basic tone: note 6, middle octave
        enable = 1'b1;
        note   = 4'd6;
        run(700);

        // Octave sweep with changes landing mid-period
        octave = 2'd0;
        run(1000);
        octave = 2'd2;
        run(300);
        octave = 2'd3;
        run(300);
        octave = 2'd1;
        run(260);

        // Note change into the middle of a period
        note = 4'd1;
        run(900);
        note = 4'd6;
        run(500);

        // Rest inputs finish the period then silence
        note = 4'd0;
        run(600);
        note = 4'd6;
        run(300);
        note = 4'd9;
        run(600);

        // Volume gating
        note   = 4'd6;
        volume = 3'd3;
        run(500);
        volume = 3'd0;
        run(500);
        volume = 3'd7;
        run(150);

        // Enable drop and reset mid-tone, then restart
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        run(300);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(300);

        // Random traffic
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 3) != 0) note = 4'($urandom_range(1, 7));
            else                           note = 4'($urandom_range(0, 15));
            octave = 2'($urandom_range(0, 3));
            volume = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
            run($urandom_range(1, 400));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
